// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the data stage.
// Data side wins by default; fetch is forced after STARVE_LIMIT data grants; stuck accesses time out.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     state_r;
    state_t     state_next_s;
    logic       grant_if_s;
    logic       grant_dm_s;
    logic       finish_s;
    logic       abort_s;
    logic [3:0] starve_cnt_r;
    logic [7:0] tmo_cnt_r;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and grant/completion decode
    always_comb begin
        state_next_s = state_r;
        grant_if_s   = 1'b0;
        grant_dm_s   = 1'b0;
        finish_s     = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (dm_req_i && !(if_req_i && (starve_cnt_r == STARVE_MAX))) begin
                    grant_dm_s   = 1'b1;
                    state_next_s = BUSY_DM;
                end else if (if_req_i) begin
                    grant_if_s   = 1'b1;
                    state_next_s = BUSY_IF;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // A late ack on the final cycle still counts as a good completion
                if (mem_ack_i) begin
                    finish_s     = 1'b1;
                    state_next_s = DONE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    abort_s      = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Memory-side request, returned data, ready/err pulses and counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            if_data_o    <= '0;
            dm_rdata_o   <= '0;
            if_ready_o   <= 1'b0;
            dm_ready_o   <= 1'b0;
            err_o        <= 1'b0;
            starve_cnt_r <= 4'd0;
            tmo_cnt_r    <= 8'd0;
        end else begin
            if_ready_o <= 1'b0;
            dm_ready_o <= 1'b0;
            err_o      <= 1'b0;
            if (grant_dm_s) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= dm_we_i;
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
                tmo_cnt_r   <= 8'd0;
                if (if_req_i && (starve_cnt_r != STARVE_MAX)) begin
                    starve_cnt_r <= starve_cnt_r + 4'd1;
                end
            end else if (grant_if_s) begin
                mem_req_o    <= 1'b1;
                mem_we_o     <= 1'b0;
                mem_addr_o   <= if_addr_i;
                mem_wdata_o  <= '0;
                tmo_cnt_r    <= 8'd0;
                starve_cnt_r <= 4'd0;
            end else if (finish_s || abort_s) begin
                mem_req_o <= 1'b0;
                err_o     <= abort_s;
                if (state_r == BUSY_IF) begin
                    if_ready_o <= 1'b1;
                    if_data_o  <= finish_s ? mem_rdata_i : '0;
                end else begin
                    dm_ready_o <= 1'b1;
                    dm_rdata_o <= finish_s ? mem_rdata_i : '0;
                end
            end else if ((state_r == BUSY_IF) || (state_r == BUSY_DM)) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end
        end
    end

    assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter; inputs change and outputs are checked at the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(64)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .stall_o(stall), .err_o(err)
    );

    task automatic test_reset;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, if_ready, dm_ready, err, stall} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000", {mem_req, mem_we, if_ready, dm_ready, err, stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_data, dm_rdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, if_data, dm_rdata});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lone_if;
        // cycle 0: request in IDLE
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0040;
        #1;
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL if_c0 stall/mem_req got %b%b exp 10", stall, mem_req);
        end
        // cycle 1: granted, no ack yet
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || stall !== 1'b1) begin
            errors++; $display("FAIL if_c1 req/we/addr/stall got %b %b %h %b exp 1 0 00000040 1", mem_req, mem_we, mem_addr, stall);
        end
        // cycle 2: memory acks
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h8C01_0004;
        #1;
        checks++;
        if (mem_req !== 1'b1 || stall !== 1'b1 || if_ready !== 1'b0) begin
            errors++; $display("FAIL if_c2 req/stall/ready got %b%b%b exp 110", mem_req, stall, if_ready);
        end
        // cycle 3: ready pulse
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        checks++;
        if (if_ready !== 1'b1 || if_data !== 32'h8C01_0004 || stall !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL if_c3 ready/data/stall/req/err got %b %h %b %b %b exp 1 8c010004 0 0 0", if_ready, if_data, stall, mem_req, err);
        end
        if_req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (if_ready !== 1'b0 || mem_req !== 1'b0 || if_data !== 32'h8C01_0004) begin
            errors++; $display("FAIL if_c4 ready/req/data got %b %b %h exp 0 0 8c010004", if_ready, mem_req, if_data);
        end
    endtask

    task automatic test_store;
        int pulses = 0;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            mem_ack = (c == 3);
            mem_rdata = 32'h0;
            #1;
            if (dm_ready) pulses++;
            if (c <= 3) begin
                checks++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL store_hold c%0d got %b %b %h %h exp 1 1 00000100 deadbeef", c, mem_req, mem_we, mem_addr, mem_wdata);
                end
            end
            if (c == 4) begin
                checks++;
                if (dm_ready !== 1'b1 || if_ready !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) begin
                    errors++; $display("FAIL store_done got rdy %b ifrdy %b req %b stall %b exp 1 0 0 0", dm_ready, if_ready, mem_req, stall);
                end
                dm_req = 1'b0; dm_we = 1'b0;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL store_pulses got %0d exp 1", pulses);
        end
    endtask

    task automatic test_starvation;
        int g = 0;
        logic got_if;
        logic exp_if;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
            end
            mem_ack = mem_req;
            mem_rdata = 32'hA000_0000 + 32'(c);
            #1;
            if (mem_req && (if_ready || dm_ready)) begin
                checks++; errors++;
                $display("FAIL starve_grant_in_done c%0d got req %b with ready exp req 0", c, mem_req);
            end
            if (mem_req) begin
                got_if = (mem_addr == 32'h200);
                exp_if = ((g % 5) == 4);
                checks++;
                if (got_if !== exp_if) begin
                    errors++; $display("FAIL starve_order grant %0d got if=%b exp if=%b", g, got_if, exp_if);
                end
                g++;
            end
            if (if_ready) begin
                checks++;
                if (if_data !== 32'hA000_0000 + 32'(c - 1)) begin
                    errors++; $display("FAIL starve_ifdata got %h exp %h", if_data, 32'hA000_0000 + 32'(c - 1));
                end
            end
        end
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
        checks++;
        if (g !== 10) begin
            errors++; $display("FAIL starve_count got %0d exp 10", g);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int busy = 0;
        bit seen = 1'b0;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; mem_ack = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (dm_ready) begin
                seen = 1'b1;
                checks++;
                if (err !== 1'b1 || dm_rdata !== 32'h0 || mem_req !== 1'b0) begin
                    errors++; $display("FAIL tmo_done err/rdata/req got %b %h %b exp 1 00000000 0", err, dm_rdata, mem_req);
                end
                dm_req = 1'b0;
            end else if (mem_req) begin
                busy++;
            end
        end
        checks++;
        if (!seen || busy !== 64) begin
            errors++; $display("FAIL tmo_busy got seen %0d cycles %0d exp 1 64", seen, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || dm_ready !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL tmo_after err/rdy/req got %b%b%b exp 000", err, dm_ready, mem_req);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h55;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || if_data === 32'h0) begin
            errors++; $display("FAIL rst_pre req/ifdata got %b %h exp 1 nonzero", mem_req, if_data);
        end
        #2;
        rst = 1'b1; dm_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, if_ready, dm_ready, err, stall} !== 6'b0 ||
            {mem_addr, mem_wdata, if_data, dm_rdata} !== 128'h0) begin
            errors++; $display("FAIL rst_async got %b %h exp 0 0", {mem_req, mem_we, if_ready, dm_ready, err, stall}, {mem_addr, mem_wdata, if_data, dm_rdata});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            mem_ack = (c == 2); mem_rdata = 32'h1234_5678;
            #1;
            checks++;
            if (dm_ready !== 1'b0 || if_ready !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0) begin
                errors++; $display("FAIL rst_late_ack c%0d got rdy %b%b req %b rdata %h exp 00 0 0", c, dm_ready, if_ready, mem_req, dm_rdata);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h400; dm_addr = 32'h500; dm_we = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1111_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        dm_req = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b1 || mem_req !== 1'b0 || if_data !== 32'h1111_0000) begin
            errors++; $display("FAIL b2b_done rdy/req/data got %b %b %h exp 1 0 11110000", if_ready, mem_req, if_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL b2b_idle req/stall got %b%b exp 01", mem_req, stall);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h2222_0000;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            errors++; $display("FAIL b2b_dm_grant req/addr got %b %h exp 1 00000500", mem_req, mem_addr);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (dm_ready !== 1'b1 || dm_rdata !== 32'h2222_0000 || if_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_dm_done rdy/rdata/ifrdy got %b %h %b exp 1 22220000 0", dm_ready, dm_rdata, if_ready);
        end
        dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h3333_0000;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin
            errors++; $display("FAIL b2b_if_grant req/addr got %b %h exp 1 00000400", mem_req, mem_addr);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (if_ready !== 1'b1 || if_data !== 32'h3333_0000) begin
            errors++; $display("FAIL b2b_if_done rdy/data got %b %h exp 1 33330000", if_ready, if_data);
        end
        if_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lone_if();
        test_store();
        test_starvation();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store driven by the EX/MEM pipeline register).
- Fixed priority to the data side (older instruction), with starvation protection for fetch and a timeout on unresponsive memory.
- Generates the global stall that freezes the pipeline registers while an access is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants made while IF waits before IF is forced; legal range 1..15.
- TIMEOUT, 64, maximum BUSY cycles without mem_ack_i before abort; legal range 2..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- if_req_i  in  1  fetch request, held until if_ready_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_data_o  out  DATA_W  fetched word, registered.
- if_ready_o  out  1  one-cycle completion pulse for IF.
- dm_req_i  in  1  data request (MemRead|MemWrite), held until dm_ready_o.
- dm_we_i  in  1  1 = store.
- dm_addr_i  in  ADDR_W  data address (ALU result).
- dm_wdata_i  in  DATA_W  store data.
- dm_rdata_o  out  DATA_W  load data, registered.
- dm_ready_o  out  1  one-cycle completion pulse for MEM.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completion, single cycle.
- stall_o  out  1  freeze PC and all pipeline registers.
- err_o  out  1  timeout pulse, coincident with the ready pulse.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs are 0, including data outputs. Starve and timeout counters clear. Any in-flight memory transaction is abandoned. A mem_ack_i received in IDLE is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE arbitration:
  - dm_req_i only: go to BUSY_DM.
  - if_req_i only: go to BUSY_IF.
  - Both: go to BUSY_DM, unless starve_cnt == STARVE_LIMIT, in which case go to BUSY_IF.
  - Neither: stay in IDLE.
- starve_cnt:
  - Increments on each DM grant made while if_req_i = 1.
  - Clears on any IF grant.
  - Saturates at STARVE_LIMIT.
- On the grant edge, register mem_req_o=1, mem_addr_o, mem_we_o (0 for IF), and mem_wdata_o (0 for IF). These stay stable until the access completes.
- BUSY_x:
  - mem_ack_i=1 at an edge: latch mem_rdata_i into if_data_o or dm_rdata_o (stores also latch it; the value is don't-care). Set mem_req_o=0 and go to DONE.
  - No ack: tmo_cnt increments. At tmo_cnt == TIMEOUT-1 without ack: set mem_req_o=0, load 0 into the owner's data output, set err_o=1, go to DONE.
- DONE (exactly one cycle):
  - The owner's ready pulses, with err_o if the access timed out.
  - No grant is made in DONE, so the requester's still-high req is never re-granted.
  - Next state is IDLE.
- Latency: req seen in IDLE at cycle 0, mem_req_o high in cycle 1, ack in cycle 1 gives ready in cycle 2. Best-case throughput is one access per 3 cycles.
- Data outputs hold their value until the next completion for the same requester.
- stall_o (combinational) = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o).
- A requester dropping req while BUSY is illegal. The block completes the access regardless and pulses ready.
- Requests are sampled only in IDLE. Requests arriving in BUSY or DONE wait.

Test Plan:
- Reset then lone IF read of 0x0000_0040; memory acks 1 cycle after mem_req_o with 0x8C01_0004 -> mem_req_o high cycles 1..2, if_ready_o pulse cycle 3, if_data_o=0x8C01_0004, stall_o high cycles 0..2 and low in cycle 3.
- Store dm_addr=0x100, wdata=0xDEADBEEF -> mem_we_o=1, mem_addr_o=0x100, mem_wdata_o=0xDEADBEEF held stable until ack; dm_ready_o pulses once.
- if_req_i and dm_req_i continuously high, immediate ack -> grant order DM,DM,DM,DM,IF,DM,... (IF every 5th grant with STARVE_LIMIT=4); no grant ever issued during DONE.
- Memory never acks, TIMEOUT=64 -> mem_req_o drops after 64 BUSY cycles; dm_ready_o and err_o pulse together; dm_rdata_o=0; FSM returns to IDLE.
- Assert rst_i asynchronously mid-BUSY_DM, then ack arrives 2 cycles after release -> all outputs 0 immediately on reset; late ack ignored, no ready pulse.
- Both requests arrive during DONE of a prior access -> neither is granted in DONE; DM granted on the following IDLE edge.
